clint_mh: RTL and testbench

- Parametrised multi-hart core-local interruptor (CLINT); successor of the single-hart CLINT.
- AXI4-Lite slave on the peripheral crossbar. Holds one shared 64-bit mtime and, per hart, an msip bit and a 64-bit mtimecmp.
- Drives per-hart msip/mtip to each core's CSR/interrupt logic.
- New capabilities: N harts, programmable tick prescale, writable mtime, level-sensitive mtip, proper ready/valid backpressure, and SLVERR on unmapped or misaligned accesses.

---
 rtl/clint_pkg.sv | 80 ++++++++
 rtl/clint_tick_gen.sv | 29 ++
 rtl/clint_mh.sv | 247 ++++++++++++++++++++++++
 tb/tb_clint_mh.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the multi-hart CLINT: address map, responses, decode helpers.
package clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned MAX_HARTS  = 16;
    localparam int unsigned HART_IDX_W = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = DATA_W / 8;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_kind_e;

    typedef enum logic {
        CH_IDLE,
        CH_RESP
    } chan_state_e;

    typedef struct packed {
        reg_kind_e               kind;
        logic [HART_IDX_W-1:0]   hart;
        logic                    hi;
        logic                    valid;
    } reg_dec_t;

    // Map a 16-bit offset onto a register; misaligned, unmapped or absent-hart offsets come back invalid.
    function automatic reg_dec_t clint_decode(input logic [15:0] off, input int unsigned nharts);
        reg_dec_t d;
        d.kind  = REG_NONE;
        d.hart  = '0;
        d.hi    = 1'b0;
        d.valid = 1'b0;
        if (off[1:0] == 2'b00) begin
            if (off[15:6] == MSIP_BASE[15:6]) begin
                d.hart = off[5:2];
                if (32'(d.hart) < nharts) begin
                    d.kind  = REG_MSIP;
                    d.valid = 1'b1;
                end
            end else if (off[15:7] == MTIMECMP_BASE[15:7]) begin
                d.hart = off[6:3];
                d.hi   = off[2];
                if (32'(d.hart) < nharts) begin
                    d.kind  = REG_MTIMECMP;
                    d.valid = 1'b1;
                end
            end else if (off[15:3] == MTIME_LO[15:3]) begin
                d.kind  = REG_MTIME;
                d.hi    = (off == MTIME_HI);
                d.valid = 1'b1;
            end
        end
        return d;
    endfunction

    // Byte-lane merge of a 32-bit write into an existing register half.
    function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_val;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) begin
                r[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler producing one mtime tick every TICK_DIV clock cycles.
module clint_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // With TICK_DIV=1 the counter is pinned at 0 and tick is permanently high.
    assign tick = (count == CNT_LAST);

    // Prescale counter: 0..TICK_DIV-1, wraps on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared mtime, per-hart msip/mtimecmp, AXI4-Lite slave.
module clint_mh
    import clint_pkg::*;
#(
    parameter int unsigned NHARTS   = 2,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       axi_araddr,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [2:0]        axi_arprot,
    output logic [31:0]       axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    input  logic [31:0]       axi_awaddr,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [2:0]        axi_awprot,
    input  logic [31:0]       axi_wdata,
    input  logic [3:0]        axi_wstrb,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [63:0]       mtime,
    output logic [NHARTS-1:0] msip,
    output logic [NHARTS-1:0] mtip
);

    localparam int unsigned TIME_W = 64;

    chan_state_e       rd_state;
    chan_state_e       rd_state_next;
    chan_state_e       wr_state;
    chan_state_e       wr_state_next;

    logic              tick;
    logic              ar_fire;
    logic              wr_fire;
    logic              wr_hit;
    reg_dec_t          rd_dec;
    reg_dec_t          wr_dec;
    logic [31:0]       rd_value;
    logic [1:0]        rd_resp_next;

    logic [TIME_W-1:0] mtime_next;
    logic [TIME_W-1:0] cmp_q    [NHARTS];
    logic [TIME_W-1:0] cmp_next [NHARTS];
    logic [NHARTS-1:0] msip_next;
    logic [NHARTS-1:0] mtip_next;

    // Address bits above the decoded window and the protection fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{axi_araddr[31:16], axi_awaddr[31:16], axi_arprot, axi_awprot};

    clint_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign ar_fire = axi_arvalid && axi_arready;
    assign wr_fire = axi_awvalid && axi_wvalid && axi_awready && axi_wready;

    // Read channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= CH_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    // Read channel next state: one read outstanding, released by the R handshake.
    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            CH_IDLE: if (ar_fire)    rd_state_next = CH_RESP;
            CH_RESP: if (axi_rready) rd_state_next = CH_IDLE;
            default:                 rd_state_next = CH_IDLE;
        endcase
    end

    // Read channel handshake outputs decoded from the registered state.
    always_comb begin
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        case (rd_state)
            CH_IDLE: axi_arready = 1'b1;
            CH_RESP: axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Write channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= CH_IDLE;
        end else begin
            wr_state <= wr_state_next;
        end
    end

    // Write channel next state: AW and W must arrive together; held until the B handshake.
    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            CH_IDLE: if (wr_fire)    wr_state_next = CH_RESP;
            CH_RESP: if (axi_bready) wr_state_next = CH_IDLE;
            default:                 wr_state_next = CH_IDLE;
        endcase
    end

    // Write channel handshake outputs decoded from the registered state.
    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (wr_state)
            CH_IDLE: begin
                axi_awready = 1'b1;
                axi_wready  = 1'b1;
            end
            CH_RESP: axi_bvalid = 1'b1;
            default: ;
        endcase
    end

    // Read mux: sees the pre-update register values of the accept cycle.
    always_comb begin
        rd_dec       = clint_decode(axi_araddr[15:0], NHARTS);
        rd_value     = '0;
        rd_resp_next = RESP_SLVERR;
        if (rd_dec.valid) begin
            rd_resp_next = RESP_OKAY;
            case (rd_dec.kind)
                REG_MSIP: begin
                    for (int h = 0; h < int'(NHARTS); h++) begin
                        if (rd_dec.hart == HART_IDX_W'(h)) begin
                            rd_value = {31'd0, msip[h]};
                        end
                    end
                end
                REG_MTIMECMP: begin
                    for (int h = 0; h < int'(NHARTS); h++) begin
                        if (rd_dec.hart == HART_IDX_W'(h)) begin
                            rd_value = rd_dec.hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
                        end
                    end
                end
                REG_MTIME: rd_value = rd_dec.hi ? mtime[63:32] : mtime[31:0];
                default:   rd_value = '0;
            endcase
        end
    end

    // Read response registers, captured on AR accept and held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_rdata <= '0;
            axi_rresp <= RESP_OKAY;
        end else if (ar_fire) begin
            axi_rdata <= rd_value;
            axi_rresp <= rd_resp_next;
        end
    end

    // Write response register, captured on write accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_bresp <= RESP_OKAY;
        end else if (wr_fire) begin
            axi_bresp <= wr_dec.valid ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Next register state: tick, then any accepted write; an mtime write suppresses that tick entirely.
    always_comb begin
        wr_dec     = clint_decode(axi_awaddr[15:0], NHARTS);
        wr_hit     = wr_fire && wr_dec.valid;
        mtime_next = tick ? mtime + TIME_W'(1) : mtime;
        msip_next  = msip;
        for (int h = 0; h < int'(NHARTS); h++) begin
            cmp_next[h] = cmp_q[h];
        end
        if (wr_hit) begin
            case (wr_dec.kind)
                REG_MSIP: begin
                    for (int h = 0; h < int'(NHARTS); h++) begin
                        if (wr_dec.hart == HART_IDX_W'(h) && axi_wstrb[0]) begin
                            msip_next[h] = axi_wdata[0];
                        end
                    end
                end
                REG_MTIMECMP: begin
                    for (int h = 0; h < int'(NHARTS); h++) begin
                        if (wr_dec.hart == HART_IDX_W'(h)) begin
                            if (wr_dec.hi) begin
                                cmp_next[h][63:32] = strb_merge(cmp_q[h][63:32], axi_wdata, axi_wstrb);
                            end else begin
                                cmp_next[h][31:0]  = strb_merge(cmp_q[h][31:0], axi_wdata, axi_wstrb);
                            end
                        end
                    end
                end
                REG_MTIME: begin
                    mtime_next = mtime;
                    if (wr_dec.hi) begin
                        mtime_next[63:32] = strb_merge(mtime[63:32], axi_wdata, axi_wstrb);
                    end else begin
                        mtime_next[31:0]  = strb_merge(mtime[31:0], axi_wdata, axi_wstrb);
                    end
                end
                default: ;
            endcase
        end
        for (int h = 0; h < int'(NHARTS); h++) begin
            mtip_next[h] = (mtime_next >= cmp_next[h]);
        end
    end

    // Timer, compare, and interrupt state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
            msip  <= '0;
            mtip  <= '0;
            for (int h = 0; h < int'(NHARTS); h++) begin
                cmp_q[h] <= '1;
            end
        end else begin
            mtime <= mtime_next;
            msip  <= msip_next;
            mtip  <= mtip_next;
            for (int h = 0; h < int'(NHARTS); h++) begin
                cmp_q[h] <= cmp_next[h];
            end
        end
    end

endmodule

// File: tb/tb_clint_mh.sv
// Testbench for clint_mh: directed scenarios plus random traffic against a behavioural model.
module tb_clint_mh;

    localparam int NH = 2;
    localparam int TD = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   axi_araddr;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [2:0]    axi_arprot;
    logic [31:0]   axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [31:0]   axi_awaddr;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [2:0]    axi_awprot;
    logic [31:0]   axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_wvalid;
    logic          axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready;
    logic [63:0]   mtime;
    logic [NH-1:0] msip;
    logic [NH-1:0] mtip;

    clint_mh #(.NHARTS(NH), .TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_araddr  (axi_araddr),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_arprot  (axi_arprot),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awprot  (axi_awprot),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .mtime       (mtime),
        .msip        (msip),
        .mtip        (mtip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0]  m_mtime;
    logic [63:0]  m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [NH-1:0] m_mtip;
    int unsigned  m_cyc;
    bit           m_rd_busy;
    bit           m_wr_busy;
    logic [31:0]  m_rdata;
    logic [1:0]   m_rresp;
    logic [1:0]   m_bresp;
    int unsigned  m_rd_cnt = 0;
    int unsigned  m_wr_cnt = 0;

    // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
    function automatic void m_decode(input logic [31:0] addr, output int kind, output int hart, output bit hi);
        int off;
        off  = int'(addr[15:0]);
        kind = 0;
        hart = 0;
        hi   = 1'b0;
        if (off % 4 != 0) return;
        if (off < 4 * NH) begin
            kind = 1;
            hart = off / 4;
        end else if (off >= 'h4000 && off < 'h4000 + 8 * NH) begin
            kind = 2;
            hart = (off - 'h4000) / 8;
            hi   = ((off - 'h4000) % 8) == 4;
        end else if (off == 'hBFF8) begin
            kind = 3;
        end else if (off == 'hBFFC) begin
            kind = 3;
            hi   = 1'b1;
        end
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    int  mk, mh;
    bit  mhi, mtick, mwrote;

    always @(posedge clk) begin
        if (rst) begin
            m_mtime   = 64'd0;
            for (int h = 0; h < NH; h++) m_cmp[h] = {64{1'b1}};
            m_msip    = '0;
            m_mtip    = '0;
            m_cyc     = 0;
            m_rd_busy = 1'b0;
            m_wr_busy = 1'b0;
            m_rdata   = 32'd0;
            m_rresp   = 2'b00;
            m_bresp   = 2'b00;
        end else begin
            mtick = (m_cyc % TD) == TD - 1;
            m_cyc++;
            if (m_rd_busy) begin
                if (axi_rready) m_rd_busy = 1'b0;
            end else if (axi_arvalid) begin
                m_decode(axi_araddr, mk, mh, mhi);
                m_rdata = 32'd0;
                m_rresp = (mk == 0) ? 2'b10 : 2'b00;
                if (mk == 1) m_rdata = {31'd0, m_msip[mh]};
                if (mk == 2) m_rdata = mhi ? m_cmp[mh][63:32] : m_cmp[mh][31:0];
                if (mk == 3) m_rdata = mhi ? m_mtime[63:32] : m_mtime[31:0];
                m_rd_busy = 1'b1;
                m_rd_cnt++;
            end
            mwrote = 1'b0;
            if (m_wr_busy) begin
                if (axi_bready) m_wr_busy = 1'b0;
            end else if (axi_awvalid && axi_wvalid) begin
                m_decode(axi_awaddr, mk, mh, mhi);
                m_bresp = (mk == 0) ? 2'b10 : 2'b00;
                if (mk == 1 && axi_wstrb[0]) m_msip[mh] = axi_wdata[0];
                if (mk == 2) begin
                    if (mhi) m_cmp[mh][63:32] = m_merge(m_cmp[mh][63:32], axi_wdata, axi_wstrb);
                    else     m_cmp[mh][31:0]  = m_merge(m_cmp[mh][31:0], axi_wdata, axi_wstrb);
                end
                if (mk == 3) begin
                    mwrote = 1'b1;
                    if (mhi) m_mtime[63:32] = m_merge(m_mtime[63:32], axi_wdata, axi_wstrb);
                    else     m_mtime[31:0]  = m_merge(m_mtime[31:0], axi_wdata, axi_wstrb);
                end
                m_wr_busy = 1'b1;
                m_wr_cnt++;
            end
            if (mtick && !mwrote) m_mtime = m_mtime + 64'd1;
            for (int h = 0; h < NH; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
        end
    end

    // Lockstep comparison of every observable output, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mtime",   mtime, m_mtime);
            chk("msip",    64'(msip), 64'(m_msip));
            chk("mtip",    64'(mtip), 64'(m_mtip));
            chk("arready", 64'(axi_arready), 64'(!m_rd_busy));
            chk("rvalid",  64'(axi_rvalid), 64'(m_rd_busy));
            chk("awready", 64'(axi_awready), 64'(!m_wr_busy));
            chk("wready",  64'(axi_wready), 64'(!m_wr_busy));
            chk("bvalid",  64'(axi_bvalid), 64'(m_wr_busy));
            if (m_rd_busy) begin
                chk("rdata", 64'(axi_rdata), 64'(m_rdata));
                chk("rresp", 64'(axi_rresp), 64'(m_rresp));
            end
            if (m_wr_busy) chk("bresp", 64'(axi_bresp), 64'(m_bresp));
        end
    end

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int unsigned c0;
        bit ok;
        c0 = m_rd_cnt;
        ok = 1'b0;
        data = 32'd0;
        resp = 2'b00;
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        axi_rready  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_rd_cnt != c0) ok = 1'b1;
        end
        chk("rd_accept", 64'(ok), 64'(1));
        data = axi_rdata;
        resp = axi_rresp;
        axi_arvalid = 1'b0;
        for (int i = 0; i < 50 && m_rd_busy; i++) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
        int unsigned c0;
        bit ok;
        c0 = m_wr_cnt;
        ok = 1'b0;
        resp = 2'b00;
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_bready  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_wr_cnt != c0) ok = 1'b1;
        end
        chk("wr_accept", 64'(ok), 64'(1));
        resp = axi_bresp;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        for (int i = 0; i < 50 && m_wr_busy; i++) @(negedge clk);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  return 32'h0000_0000;
            1:  return 32'h0000_0004;
            2:  return 32'h0000_0008;
            3:  return 32'h0000_4000;
            4:  return 32'h0000_4004;
            5:  return 32'h0000_4008;
            6:  return 32'h0000_400C;
            7:  return 32'h0000_BFF8;
            8:  return 32'h0000_BFFC;
            9:  return 32'h0000_0002;
            10: return 32'h0000_5000;
            default: return {r[31:16], 16'hBFF8};
        endcase
    endfunction

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: return 32'($urandom_range(0, 300));
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            default: return 32'h0000_0001;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  bs;
    logic [31:0] hold_rdata;
    int unsigned c_rd0, c_wr0;
    bit ok2;

    initial begin
        rst = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = '0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = '0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_arready", 64'(axi_arready), 64'(1));
        chk("rst_mtime", mtime, 64'd0);
        rst = 1'b0;

        // idle, then sample mtime
        repeat (10) @(negedge clk);
        do_read(32'h0000_BFF8, rd, rs);
        chk("idle_mtime_resp", 64'(rs), 64'(0));
        chk("idle_mtip", 64'(mtip), 64'(0));
        chk("idle_msip", 64'(msip), 64'(0));

        // clear mtime, then watch it advance once per TD cycles
        do_write(32'h0000_BFF8, 32'd0, 4'hF, bs);
        do_write(32'h0000_BFFC, 32'd0, 4'hF, bs);
        for (int i = 0; i < 12; i++) do_read(32'h0000_BFF8, rd, rs);

        // timer interrupt on hart 1
        do_write(32'h0000_400C, 32'd0, 4'hF, bs);
        do_write(32'h0000_4008, m_mtime[31:0] + 32'd20, 4'hF, bs);
        repeat (30 * TD) @(negedge clk);
        chk("mtip1_set", 64'(mtip[1]), 64'(1));
        chk("mtip0_clear", 64'(mtip[0]), 64'(0));
        do_write(32'h0000_400C, 32'hFFFF_FFFF, 4'hF, bs);
        chk("mtip1_drop", 64'(mtip[1]), 64'(0));

        // software interrupt with and without strobe
        do_write(32'h0000_0004, 32'd1, 4'b0001, bs);
        chk("msip_set", 64'(msip), 64'(2'b10));
        do_write(32'h0000_0004, 32'd0, 4'b0000, bs);
        chk("msip_nostrb", 64'(msip), 64'(2'b10));
        do_read(32'h0000_0004, rd, rs);
        chk("msip_read", 64'(rd), 64'(1));

        // error responses
        do_read(32'h0000_0008, rd, rs);
        chk("absent_rresp", 64'(rs), 64'(2'b10));
        chk("absent_rdata", 64'(rd), 64'(0));
        do_read(32'h0000_0002, rd, rs);
        chk("misalign_rresp", 64'(rs), 64'(2'b10));
        do_write(32'h0000_5000, 32'hFFFF_FFFF, 4'hF, bs);
        chk("unmapped_bresp", 64'(bs), 64'(2'b10));
        do_write(32'h0000_0008, 32'd1, 4'hF, bs);
        chk("absent_msip", 64'(msip), 64'(2'b10));

        // read backpressure with a second AR waiting
        c_rd0 = m_rd_cnt;
        axi_araddr = 32'h0000_BFF8; axi_arvalid = 1'b1; axi_rready = 1'b0;
        @(negedge clk);
        hold_rdata = m_rdata;
        axi_araddr = 32'h0000_0004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_arready", 64'(axi_arready), 64'(0));
            chk("bp_rvalid", 64'(axi_rvalid), 64'(1));
            chk("bp_rdata", 64'(axi_rdata), 64'(hold_rdata));
        end
        chk("bp_single", 64'(m_rd_cnt), 64'(c_rd0 + 1));
        axi_rready = 1'b1;
        ok2 = 1'b0;
        for (int i = 0; i < 20 && !ok2; i++) begin
            @(negedge clk);
            if (m_rd_cnt == c_rd0 + 2) ok2 = 1'b1;
        end
        chk("bp_second_accept", 64'(ok2), 64'(1));
        chk("bp_second_rdata", 64'(axi_rdata), 64'(1));
        axi_arvalid = 1'b0;
        for (int i = 0; i < 20 && m_rd_busy; i++) @(negedge clk);

        // AW without W is not accepted
        c_wr0 = m_wr_cnt;
        axi_awaddr = 32'h0000_0000; axi_wdata = 32'd1; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b0; axi_bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("aw_only_bvalid", 64'(axi_bvalid), 64'(0));
        end
        axi_wvalid = 1'b1;
        @(negedge clk);
        chk("aw_w_bvalid", 64'(axi_bvalid), 64'(1));
        chk("aw_w_count", 64'(m_wr_cnt), 64'(c_wr0 + 1));
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        @(negedge clk);
        chk("aw_w_msip", 64'(msip), 64'(2'b11));

        // random traffic, with one reset in the middle
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst         = (cyc == 1000);
            axi_arvalid = ($urandom_range(0, 2) == 0);
            axi_araddr  = pick_addr();
            axi_rready  = $urandom_range(0, 1) == 1;
            axi_awvalid = $urandom_range(0, 1) == 1;
            axi_wvalid  = $urandom_range(0, 1) == 1;
            axi_awaddr  = pick_addr();
            axi_wdata   = pick_data();
            axi_wstrb   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            axi_bready  = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        rst = 1'b0;
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_rready = 1'b1; axi_bready = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
